// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - default geometry and threshold constants for the FIFO controller
package fifo_pkg;
    localparam int DEF_RAM_WIDTH = 10;
    localparam int DEF_RAM_DEPTH = 8;
    localparam int DEF_ADDR_SIZE = 3;
    localparam int DEF_AF_THRESH = 6;
    localparam int DEF_AE_THRESH = 1;
endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping address pointer, advances on inc and wraps DEPTH-1 -> 0
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_RAM_DEPTH,
    parameter int AW    = DEF_ADDR_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] r_ptr;

    // Explicit compare against LAST keeps non-power-of-two depths correct.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + AW'(1);
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO controller driving an external dual-port RAM as writer and reader
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [RAM_WIDTH-1:0] data_in,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic [RAM_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic [ADDR_SIZE:0]   count,
    output logic                 mem_wr_enb,
    output logic [ADDR_SIZE-1:0] mem_wr_addr,
    output logic [RAM_WIDTH-1:0] mem_data_in,
    output logic                 mem_rd_enb,
    output logic [ADDR_SIZE-1:0] mem_rd_addr,
    input  logic [RAM_WIDTH-1:0] mem_data_out
);
    localparam int CW = ADDR_SIZE + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAM_DEPTH - 1);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    logic [CW-1:0]        r_count;
    logic [RAM_WIDTH-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic [ADDR_SIZE-1:0] w_wr_ptr;
    logic [ADDR_SIZE-1:0] w_rd_ptr;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = push & (~w_full | w_pop_ok);

    fifo_ptr #(.DEPTH(RAM_DEPTH), .AW(ADDR_SIZE)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push_ok),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.DEPTH(RAM_DEPTH), .AW(ADDR_SIZE)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pop_ok),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_data_out <= mem_data_out;
            end
        end
    end

    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (push & ~w_push_ok) | (r_overflow & ~err_clr);
            r_underflow <= (pop & ~w_pop_ok) | (r_underflow & ~err_clr);
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign count        = r_count;
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign mem_wr_enb   = w_push_ok;
    assign mem_wr_addr  = w_wr_ptr;
    assign mem_data_in  = data_in;
    assign mem_rd_enb   = w_pop_ok;
    assign mem_rd_addr  = w_rd_ptr;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl with a behavioural memoria RAM
module tb_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic [9:0] data_in = '0;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [9:0] data_out;
    logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;
    logic       mem_wr_enb, mem_rd_enb;
    logic [2:0] mem_wr_addr, mem_rd_addr;
    logic [9:0] mem_data_in, mem_data_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] mem [0:7];

    always #5 clk = ~clk;

    // RAM wipes the addressed slot on any edge without a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (mem_wr_enb) begin
            mem[mem_wr_addr] <= mem_data_in;
        end else begin
            mem[mem_wr_addr] <= '0;
        end
    end
    assign mem_data_out = mem[mem_rd_addr];

    fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .count        (count),
        .mem_wr_enb   (mem_wr_enb),
        .mem_wr_addr  (mem_wr_addr),
        .mem_data_in  (mem_data_in),
        .mem_rd_enb   (mem_rd_enb),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_out (mem_data_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 0101", {full, empty, almost_full, almost_empty});
        end
        n_checks++;
        if ({count, data_valid, overflow, underflow, data_out} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_state: count=%0d dv=%b ovf=%b unf=%b dout=%h expected all zero",
                     count, data_valid, overflow, underflow, data_out);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        push = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            data_in = 10'(i);
            tick();
            if (i == 6) begin
                n_checks++;
                if ({almost_full, full} !== 2'b10) begin
                    n_errors++;
                    $display("FAIL fill_af6: got af=%b full=%b expected af=1 full=0", almost_full, full);
                end
            end
        end
        n_checks++;
        if (count !== 4'd7 || full !== 1'b1 || almost_full !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_full: count=%0d full=%b af=%b expected 7 1 1", count, full, almost_full);
        end
        data_in = 10'h008;
        #1;
        n_checks++;
        if (mem_wr_enb !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_drop_wren: got %b expected 0", mem_wr_enb);
        end
        tick();
        push = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || count !== 4'd7) begin
            n_errors++;
            $display("FAIL fill_overflow: ovf=%b count=%0d expected 1 7", overflow, count);
        end
    endtask

    task automatic test_drain();
        tick();
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_idle_dv: got %b expected 0", data_valid);
        end
        pop = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (data_out !== 10'(i) || data_valid !== 1'b1 || count !== 4'(7 - i)) begin
                n_errors++;
                $display("FAIL drain_word%0d: dout=%h dv=%b count=%0d expected %h 1 %0d",
                         i, data_out, data_valid, count, 10'(i), 7 - i);
            end
        end
        pop = 1'b0;
        tick();
        n_checks++;
        if (data_valid !== 1'b0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_empty: dv=%b empty=%b expected 0 1", data_valid, empty);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_checks++;
        if (underflow !== 1'b1 || data_valid !== 1'b0 || data_out !== 10'h007) begin
            n_errors++;
            $display("FAIL drain_underflow: unf=%b dv=%b dout=%h expected 1 0 007", underflow, data_valid, data_out);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_errclr: ovf=%b unf=%b expected 0 0", overflow, underflow);
        end
    endtask

    task automatic test_back_to_back();
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 10'h100 + 10'(i);
            tick();
        end
        pop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 10'h103 + 10'(i);
            tick();
            n_checks++;
            if (data_out !== 10'h100 + 10'(i) || count !== 4'd3 || data_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_cycle%0d: dout=%h count=%0d dv=%b expected %h 3 1",
                         i, data_out, count, data_valid, 10'h100 + 10'(i));
            end
        end
        push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (data_out !== 10'h114 + 10'(i)) begin
                n_errors++;
                $display("FAIL b2b_tail%0d: got %h expected %h", i, data_out, 10'h114 + 10'(i));
            end
        end
        pop = 1'b0;
        tick();
        n_checks++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_end: empty=%b unf=%b expected 1 0", empty, underflow);
        end
    endtask

    task automatic test_empty_pushpop();
        push = 1'b1;
        pop = 1'b1;
        data_in = 10'h155;
        tick();
        push = 1'b0;
        n_checks++;
        if (underflow !== 1'b1 || count !== 4'd1 || data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_pp: unf=%b count=%0d dv=%b expected 1 1 0", underflow, count, data_valid);
        end
        tick();
        pop = 1'b0;
        n_checks++;
        if (data_out !== 10'h155 || data_valid !== 1'b1 || count !== 4'd0) begin
            n_errors++;
            $display("FAIL empty_pp_read: dout=%h dv=%b count=%0d expected 155 1 0", data_out, data_valid, count);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_full_pushpop();
        push = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = 10'h200 + 10'(i);
            tick();
        end
        pop = 1'b1;
        data_in = 10'h2AA;
        tick();
        push = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || count !== 4'd7 || full !== 1'b1 || data_out !== 10'h200) begin
            n_errors++;
            $display("FAIL full_pp: ovf=%b count=%0d full=%b dout=%h expected 0 7 1 200",
                     overflow, count, full, data_out);
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (data_out !== ((i < 7) ? 10'h200 + 10'(i) : 10'h2AA)) begin
                n_errors++;
                $display("FAIL full_pp_read%0d: got %h expected %h", i, data_out,
                         (i < 7) ? 10'h200 + 10'(i) : 10'h2AA);
            end
        end
        pop = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 10'h300 + 10'(i);
            tick();
        end
        push = 1'b0;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_checks++;
        if (count !== 4'd4 || data_valid !== 1'b1 || data_out !== 10'h300) begin
            n_errors++;
            $display("FAIL midrst_pre: count=%0d dv=%b dout=%h expected 4 1 300", count, data_valid, data_out);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (count !== 4'd0 || data_valid !== 1'b0 || data_out !== 10'h000 || empty !== 1'b1
            || almost_empty !== 1'b1 || mem_wr_addr !== 3'd0 || mem_rd_addr !== 3'd0) begin
            n_errors++;
            $display("FAIL midrst_async: count=%0d dv=%b dout=%h empty=%b ae=%b wa=%0d ra=%0d expected 0 0 000 1 1 0 0",
                     count, data_valid, data_out, empty, almost_empty, mem_wr_addr, mem_rd_addr);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_err_clr();
        pop = 1'b1;
        err_clr = 1'b1;
        tick();
        n_checks++;
        if (underflow !== 1'b1) begin
            n_errors++;
            $display("FAIL errclr_unf_wins: got %b expected 1", underflow);
        end
        pop = 1'b0;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL errclr_unf_clear: got %b expected 0", underflow);
        end
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 10'h3C0 + 10'(i);
            tick();
        end
        err_clr = 1'b1;
        tick();
        n_checks++;
        if (overflow !== 1'b1 || count !== 4'd7) begin
            n_errors++;
            $display("FAIL errclr_ovf_wins: ovf=%b count=%0d expected 1 7", overflow, count);
        end
        push = 1'b0;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL errclr_ovf_clear: ovf=%b unf=%b expected 0 0", overflow, underflow);
        end
        tick();
        n_checks++;
        if (overflow !== 1'b0 || count !== 4'd7) begin
            n_errors++;
            $display("FAIL errclr_hold: ovf=%b count=%0d expected 0 7", overflow, count);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_empty_pushpop();
        test_full_pushpop();
        test_mid_reset();
        test_err_clr();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the team's dual-port 'memoria' RAM, acting as its writer and reader.
- Owns the write/read pointers, occupancy count, status flags and the registered read-data output.
- Sits between a producer (push/data_in) and a consumer (pop/data_out) in the PCIe datapath buffers.
- 'memoria' clears mem[wr_addr] on every clock edge where wr_enb=0. The controller therefore always keeps wr_addr on a free slot, so usable capacity is RAM_DEPTH-1.

Parameters:
- RAM_WIDTH, 10, data word width
- RAM_DEPTH, 8, number of RAM entries; FIFO capacity is RAM_DEPTH-1
- ADDR_SIZE, 3, RAM address width; ceil(log2(RAM_DEPTH))
- AF_THRESH, 6, almost_full asserted when count >= AF_THRESH
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- push  in  1  write request from producer
- data_in  in  RAM_WIDTH  write data
- pop  in  1  read request from consumer
- err_clr  in  1  synchronous clear of the sticky error flags
- data_out  out  RAM_WIDTH  registered read data
- data_valid  out  1  one-cycle pulse marking data_out as fresh
- full  out  1  count == RAM_DEPTH-1
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- overflow  out  1  sticky: push rejected because FIFO was full
- underflow  out  1  sticky: pop rejected because FIFO was empty
- count  out  ADDR_SIZE+1  current occupancy
- mem_wr_enb  out  1  to RAM wr_enb
- mem_wr_addr  out  ADDR_SIZE  to RAM wr_addr
- mem_data_in  out  RAM_WIDTH  to RAM data_in
- mem_rd_enb  out  1  to RAM rd_enb
- mem_rd_addr  out  ADDR_SIZE  to RAM rd_addr
- mem_data_out  in  RAM_WIDTH  from RAM data_out; combinational read

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0. The flags settle to empty=1, almost_empty=1, full=0, almost_full=0.
- Reset mid-operation discards all contents; the RAM is cleared by its own reset on the same rst.
- Accept conditions:
  - push_ok = push & (~full | pop_ok)
  - pop_ok = pop & ~empty
- Combinational RAM drive:
  - mem_wr_enb = push_ok
  - mem_wr_addr = wr_ptr at all times
  - mem_data_in = data_in
  - mem_rd_enb = pop_ok
  - mem_rd_addr = rd_ptr
- wr_ptr always addresses a free slot, so the idle-cycle clear in the RAM never destroys stored data.
- Pointer update on each clk: on acceptance, a pointer advances by 1 and wraps from RAM_DEPTH-1 to 0. Non-power-of-two depths must be supported.
- count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither. count never exceeds RAM_DEPTH-1 and never drops below 0.
- Read latency: data_out <= mem_data_out at the edge that accepts a pop, with data_valid=1 in the following cycle. Otherwise data_out holds its last value and data_valid=0.
- Simultaneous push+pop when empty: pop rejected, underflow set, push accepted, count becomes 1.
- Simultaneous push+pop when full: both accepted, count unchanged at RAM_DEPTH-1. The write lands in the free slot, which differs from rd_ptr.
- Push when full without pop: data dropped, pointers unchanged, overflow set.
- Pop when empty: underflow set, data_out held, data_valid=0.
- Errors: overflow and underflow are sticky until err_clr=1 at a clock edge. If a new error and err_clr occur in the same cycle, the error wins and the flag stays 1.
- Flags are decoded from the registered count; no combinational path from push/pop to any flag.

Decomposition:
- Shared package fifo_pkg holds the default width/depth/address constants and the threshold defaults.
- No typedefs are needed.
- Natural sub-module: fifo_ptr, a wrapping pointer counter with inc input and DEPTH parameter, instantiated twice.
- 'memoria' is instantiated alongside fifo_ctrl at the level above it, not inside it.

Test Plan:
- Reset, then 7 pushes of 0x001..0x007 -> count=7, full=1, almost_full=1 after 6 pushes; 8th push 0x008 sets overflow=1 and is dropped.
- 7 pops after the fill -> data_out = 0x001..0x007 in order, each with data_valid pulsed one cycle after its pop; empty=1 at end; a further pop sets underflow=1.
- Continuous push+pop for 20 cycles starting at count=3 -> count stays 3; both pointers wrap 7->0 without corruption; output order matches input order.
- push+pop together when empty with data_in=0x155 -> underflow=1, count=1; the next pop returns 0x155.
- push+pop together when full -> overflow stays 0, count stays 7, the newly written word is read out 7 pops later.
- Drive rst low mid-stream at count=4 -> all outputs return to reset values immediately (asynchronous); err_clr clears sticky flags only when no new error occurs in the same cycle.
